// File: rtl/mpt_walking_stage.sv
// mpt_walking_stage: one MPT walker pipeline stage.
//
// Purpose: takes an mptw_transaction_t whose mpte field holds the physical
// address of the next MPT entry, fetches that 64-bit entry with a single
// read, replaces mpte with the fetched entry and forwards the transaction.
// Transactions already marked MPT_WALKING_SKIP (or not valid) bypass memory.
// Misaligned entry addresses, bus errors and response timeouts terminate the
// walk (mpte=0, completed=1, walking=SKIP) and pulse bus_error_o.
//
// Ports:
//   clk_i, rst_ni                 clock, asynchronous active-low reset
//   stage_slave_valid/ready/data  upstream transaction handshake
//   stage_master_valid/ready/data downstream transaction handshake
//   mem_req_o/gnt_i/addr_o        read request channel (we/be/wdata constant)
//   mem_valid_i/rdata_i/error_i   read response channel
//   bus_error_o                   one-cycle pulse on misalign/bus error/timeout

package mpt_walking_pkg;

  localparam int XLEN = 64;

  localparam logic [1:0] MPT_WALKING_SKIP = 2'd2;

  // Transaction layout shared with the neighbouring walker stages.
  typedef struct packed {
    logic [7:0]  txn_id;
    logic        valid;
    logic        completed;
    logic [1:0]  walking;
    logic [63:0] mpte;
  } mptw_transaction_t;

endpackage

module mpt_walking_stage
  import mpt_walking_pkg::*;
#(
  parameter int PIPELINE_DATA_WIDTH = $bits(mptw_transaction_t),
  parameter int WALKING_LEVEL       = 0,
  parameter int MEM_ADDR_WIDTH      = XLEN,
  parameter int TIMEOUT_CYCLES      = 256
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           stage_slave_valid,
  output logic                           stage_slave_ready,
  input  logic [PIPELINE_DATA_WIDTH-1:0] stage_slave_data,
  output logic                           stage_master_valid,
  input  logic                           stage_master_ready,
  output logic [PIPELINE_DATA_WIDTH-1:0] stage_master_data,
  output logic                           mem_req_o,
  input  logic                           mem_gnt_i,
  output logic [MEM_ADDR_WIDTH-1:0]      mem_addr_o,
  output logic                           mem_we_o,
  output logic [7:0]                     mem_be_o,
  output logic [63:0]                    mem_wdata_o,
  input  logic                           mem_valid_i,
  input  logic [63:0]                    mem_rdata_i,
  input  logic                           mem_error_i,
  output logic                           bus_error_o
);

  // The level is informational only; it is not copied into any field.
  localparam int unused_walking_level = WALKING_LEVEL;

  // One-hot so that mem_req_o and stage_master_valid are plain flop bits.
  localparam logic [3:0] S_IDLE = 4'b0001;
  localparam logic [3:0] S_REQ  = 4'b0010;
  localparam logic [3:0] S_WAIT = 4'b0100;
  localparam logic [3:0] S_OUT  = 4'b1000;

  localparam int                CNT_W   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0]  TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  // Terminates a walk: invalid entry, walk completed, later stages skip it.
  function automatic mptw_transaction_t fault_txn(input mptw_transaction_t t);
    mptw_transaction_t r;
    r           = t;
    r.mpte      = 64'h0;
    r.completed = 1'b1;
    r.walking   = MPT_WALKING_SKIP;
    return r;
  endfunction

  mptw_transaction_t slave_txn_s;
  mptw_transaction_t txn_q, txn_d;
  logic [3:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              drain_q, drain_d;
  logic              slave_ready_q, slave_ready_d;
  logic              bus_error_q, bus_error_d;
  logic              slave_hs_s;

  assign slave_txn_s = stage_slave_data;
  assign slave_hs_s  = stage_slave_valid && slave_ready_q;

  // Next-state, buffer, timeout counter and drain computation.
  always_comb begin
    state_d     = state_q;
    txn_d       = txn_q;
    cnt_d       = cnt_q;
    bus_error_d = 1'b0;
    // A late response after a timeout is swallowed here and nowhere else.
    if (drain_q && mem_valid_i) begin
      drain_d = 1'b0;
    end else begin
      drain_d = drain_q;
    end
    case (state_q)
      S_IDLE: begin
        if (slave_hs_s) begin
          txn_d = slave_txn_s;
          if ((slave_txn_s.walking == MPT_WALKING_SKIP) || !slave_txn_s.valid) begin
            state_d = S_OUT;
          end else if (slave_txn_s.mpte[2:0] != 3'b000) begin
            txn_d       = fault_txn(slave_txn_s);
            bus_error_d = 1'b1;
            state_d     = S_OUT;
          end else begin
            state_d = S_REQ;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_REQ: begin
        if (mem_gnt_i) begin
          cnt_d = {CNT_W{1'b0}};
          // Zero-latency response arriving together with the grant.
          if (mem_valid_i) begin
            state_d = S_OUT;
            if (mem_error_i) begin
              txn_d       = fault_txn(txn_q);
              bus_error_d = 1'b1;
            end else begin
              txn_d.mpte = mem_rdata_i;
            end
          end else begin
            state_d = S_WAIT;
          end
        end else begin
          state_d = S_REQ;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        if (mem_valid_i) begin
          state_d = S_OUT;
          if (mem_error_i) begin
            txn_d       = fault_txn(txn_q);
            bus_error_d = 1'b1;
          end else begin
            txn_d.mpte = mem_rdata_i;
          end
        end else if ((TIMEOUT_CYCLES != 0) && (cnt_q == TO_LAST)) begin
          // The read is still outstanding: remember to drop its response.
          txn_d       = fault_txn(txn_q);
          bus_error_d = 1'b1;
          drain_d     = 1'b1;
          state_d     = S_OUT;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_OUT: begin
        if (stage_master_ready) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_OUT;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    // Registered ready; the OUT->IDLE cycle itself never accepts.
    slave_ready_d = (state_d == S_IDLE) && !drain_d;
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= S_IDLE;
      txn_q         <= '0;
      cnt_q         <= {CNT_W{1'b0}};
      drain_q       <= 1'b0;
      slave_ready_q <= 1'b0;
      bus_error_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      txn_q         <= txn_d;
      cnt_q         <= cnt_d;
      drain_q       <= drain_d;
      slave_ready_q <= slave_ready_d;
      bus_error_q   <= bus_error_d;
    end
  end

  assign stage_slave_ready  = slave_ready_q;
  assign stage_master_valid = state_q[3];
  assign stage_master_data  = txn_q;
  assign mem_req_o          = state_q[1];
  assign mem_addr_o         = txn_q.mpte[MEM_ADDR_WIDTH-1:0];
  assign mem_we_o           = 1'b0;
  assign mem_be_o           = 8'hFF;
  assign mem_wdata_o        = 64'h0;
  assign bus_error_o        = bus_error_q;

endmodule

// File: tb/tb_mpt_walking_stage.sv
// Directed, table-driven bench for mpt_walking_stage (TIMEOUT_CYCLES=4).
module tb_mpt_walking_stage;
  import mpt_walking_pkg::*;

  localparam int DW = $bits(mptw_transaction_t);

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  logic          stage_slave_valid = 1'b0;
  logic          stage_slave_ready;
  logic [DW-1:0] stage_slave_data = '0;
  logic          stage_master_valid;
  logic          stage_master_ready = 1'b0;
  logic [DW-1:0] stage_master_data;
  logic          mem_req_o;
  logic          mem_gnt_i = 1'b0;
  logic [63:0]   mem_addr_o;
  logic          mem_we_o;
  logic [7:0]    mem_be_o;
  logic [63:0]   mem_wdata_o;
  logic          mem_valid_i = 1'b0;
  logic [63:0]   mem_rdata_i = 64'h0;
  logic          mem_error_i = 1'b0;
  logic          bus_error_o;

  mpt_walking_stage #(.TIMEOUT_CYCLES(4)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .stage_slave_valid(stage_slave_valid), .stage_slave_ready(stage_slave_ready),
    .stage_slave_data(stage_slave_data),
    .stage_master_valid(stage_master_valid), .stage_master_ready(stage_master_ready),
    .stage_master_data(stage_master_data),
    .mem_req_o(mem_req_o), .mem_gnt_i(mem_gnt_i), .mem_addr_o(mem_addr_o),
    .mem_we_o(mem_we_o), .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o),
    .mem_valid_i(mem_valid_i), .mem_rdata_i(mem_rdata_i), .mem_error_i(mem_error_i),
    .bus_error_o(bus_error_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    mptw_transaction_t din;
    int                gnt_dly;   // REQ cycles before grant
    int                rsp_dly;   // cycles from grant cycle to rvalid (0 = same cycle)
    logic [63:0]       rdata;
    logic              rerr;
    int                hold;      // cycles master_ready held low
    mptw_transaction_t dout;
    int                lat;       // cycle of master_valid after accept cycle 0
    int                req_cycles;
    int                err_pulses;
  } vec_t;

  int   n_checks = 0;
  int   n_fail   = 0;
  vec_t vecs[7];

  function automatic mptw_transaction_t mk(input logic [7:0] id, input logic v, input logic c,
                                           input logic [1:0] w, input logic [63:0] m);
    mptw_transaction_t t;
    t.txn_id = id; t.valid = v; t.completed = c; t.walking = w; t.mpte = m;
    return t;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic wait_ready(input string name);
    int n;
    n = 0;
    while (!stage_slave_ready && n < 20) begin
      tick();
      n++;
    end
    check({name, "_ready_timeout"}, stage_slave_ready, 1'b1);
  endtask

  task automatic send(input mptw_transaction_t t);
    stage_slave_data  = t;
    stage_slave_valid = 1'b1;
    tick();
    stage_slave_valid = 1'b0;
    stage_slave_data  = '0;
  endtask

  task automatic run_txn(input vec_t v, input string nm);
    int cyc, req_n, err_n, lat, gnt_cyc, req_wait;
    wait_ready(nm);
    send(v.din);
    req_n = 0; err_n = 0; lat = -1; gnt_cyc = -1; req_wait = 0;
    for (cyc = 1; cyc <= 40 && lat < 0; cyc++) begin
      mem_gnt_i = 1'b0; mem_valid_i = 1'b0; mem_error_i = 1'b0; mem_rdata_i = 64'h0;
      if (bus_error_o) err_n++;
      if (mem_req_o) begin
        req_n++;
        check({nm, "_addr"}, {mem_we_o, mem_addr_o}, {1'b0, v.din.mpte});
        if (req_wait == v.gnt_dly) begin
          mem_gnt_i = 1'b1;
          gnt_cyc   = cyc;
        end
        req_wait++;
      end
      if (gnt_cyc >= 0 && cyc == gnt_cyc + v.rsp_dly) begin
        mem_valid_i = 1'b1; mem_rdata_i = v.rdata; mem_error_i = v.rerr;
      end
      if (stage_master_valid) lat = cyc;
      else tick();
    end
    check({nm, "_latency"}, lat, v.lat);
    check({nm, "_data"}, stage_master_data, v.dout);
    for (int h = 0; h < v.hold; h++) begin
      tick();
      if (bus_error_o) err_n++;
      check({nm, "_hold"}, {stage_master_valid, stage_slave_ready, stage_master_data},
            {1'b1, 1'b0, v.dout});
    end
    stage_master_ready = 1'b1;
    tick();
    stage_master_ready = 1'b0;
    if (bus_error_o) err_n++;
    check({nm, "_released"}, stage_master_valid, 1'b0);
    check({nm, "_req_cycles"}, req_n, v.req_cycles);
    check({nm, "_bus_error"}, err_n, v.err_pulses);
  endtask

  initial begin
    // Table: {din, gnt_dly, rsp_dly, rdata, rerr, hold, dout, lat, req_cycles, err_pulses}
    vecs[0] = '{mk(8'h11, 1'b1, 1'b0, MPT_WALKING_SKIP, 64'h1234), 0, 0, 64'h0, 1'b0, 0,
                mk(8'h11, 1'b1, 1'b0, MPT_WALKING_SKIP, 64'h1234), 1, 0, 0};
    vecs[1] = '{mk(8'h22, 1'b1, 1'b0, 2'd1, 64'h8000_1000), 0, 3, 64'h0000_0000_0040_0001, 1'b0, 0,
                mk(8'h22, 1'b1, 1'b0, 2'd1, 64'h0000_0000_0040_0001), 5, 1, 0};
    vecs[2] = '{mk(8'h33, 1'b1, 1'b0, 2'd0, 64'h9000_0008), 0, 0, 64'hDEAD_BEEF_0000_0007, 1'b0, 0,
                mk(8'h33, 1'b1, 1'b0, 2'd0, 64'hDEAD_BEEF_0000_0007), 2, 1, 0};
    vecs[3] = '{mk(8'h44, 1'b1, 1'b1, 2'd1, 64'h8000_0100), 2, 1, 64'h1111_2222_3333_4441, 1'b0, 0,
                mk(8'h44, 1'b1, 1'b1, 2'd1, 64'h1111_2222_3333_4441), 5, 3, 0};
    vecs[4] = '{mk(8'h55, 1'b1, 1'b0, 2'd1, 64'h8000_1004), 0, 0, 64'h0, 1'b0, 0,
                mk(8'h55, 1'b1, 1'b1, MPT_WALKING_SKIP, 64'h0), 1, 0, 1};
    vecs[5] = '{mk(8'h66, 1'b0, 1'b0, 2'd1, 64'h8000_1004), 0, 0, 64'h0, 1'b0, 0,
                mk(8'h66, 1'b0, 1'b0, 2'd1, 64'h8000_1004), 1, 0, 0};
    vecs[6] = '{mk(8'h77, 1'b1, 1'b0, 2'd1, 64'h8000_2000), 0, 1, 64'hFFFF, 1'b1, 5,
                mk(8'h77, 1'b1, 1'b1, MPT_WALKING_SKIP, 64'h0), 3, 1, 1};

    // Reset state
    #1;
    check("reset_outputs",
          {stage_slave_ready, stage_master_valid, mem_req_o, mem_we_o, bus_error_o, mem_be_o},
          {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'hFF});
    check("reset_data", {stage_master_data, mem_addr_o, mem_wdata_o}, '0);
    tick();
    rst_ni = 1'b1;
    tick();

    for (int i = 0; i < 7; i++) run_txn(vecs[i], $sformatf("vec%0d", i));

    // Timeout: grant at cycle 1, no response, late rvalid at cycle 10 is dropped
    wait_ready("timeout");
    send(mk(8'h88, 1'b1, 1'b0, 2'd1, 64'h8000_3000));
    stage_master_ready = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      mem_gnt_i   = (c == 1);
      mem_valid_i = (c == 10);
      mem_rdata_i = (c == 10) ? 64'h5555_5555_5555_5550 : 64'h0;
      check($sformatf("timeout_c%0d", c),
            {mem_req_o, stage_master_valid, bus_error_o, stage_slave_ready},
            {c == 1, c == 6, c == 6, c >= 11});
      if (c == 6)
        check("timeout_data", stage_master_data, mk(8'h88, 1'b1, 1'b1, MPT_WALKING_SKIP, 64'h0));
      tick();
    end
    mem_gnt_i = 1'b0; mem_valid_i = 1'b0; mem_rdata_i = 64'h0;
    stage_master_ready = 1'b0;

    // Asynchronous reset while waiting for the response
    wait_ready("rst_wait");
    send(mk(8'h99, 1'b1, 1'b0, 2'd1, 64'h8000_4000));
    mem_gnt_i = 1'b1;
    tick();
    mem_gnt_i = 1'b0;
    #3;
    rst_ni = 1'b0;
    #1;
    check("midrst_outputs",
          {stage_slave_ready, stage_master_valid, mem_req_o, bus_error_o, mem_be_o},
          {1'b0, 1'b0, 1'b0, 1'b0, 8'hFF});
    check("midrst_data", {stage_master_data, mem_addr_o}, '0);
    tick();
    rst_ni = 1'b1;
    tick();
    run_txn(vecs[1], "after_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
